// File: rtl/ifu_fetch_pkg.sv
// rtl/ifu_fetch_pkg.sv - shared core constants, fetch buffer entry type and PC helpers
package ifu_fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSTR_BYTES);
  endfunction

  function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] pc);
    return pc & ~XLEN'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO holding fetched {pc, instr} entries, with flush
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];
  assign count     = cnt;

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit: credit-based issue, 2-cycle memory tag pipeline, buffer
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int              BUF_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] s1_pc;
  logic [XLEN-1:0] s2_pc;
  logic            s1_v;
  logic            s2_v;
  logic [CW-1:0]   buf_count;
  logic [CW:0]     used;
  logic            issue;
  logic            push;
  logic            pop;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;

  // In-flight requests hold a buffer slot, so a push can never find the buffer full.
  assign used  = {1'b0, buf_count} + (CW+1)'(s1_v) + (CW+1)'(s2_v);
  assign issue = !rst && !redirect_valid && (used < (CW+1)'(BUF_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      s1_v  <= 1'b0;
      s2_v  <= 1'b0;
      s1_pc <= '0;
      s2_pc <= '0;
    end else if (redirect_valid) begin
      pc    <= pc_align(redirect_pc);
      s1_v  <= 1'b0;
      s2_v  <= 1'b0;
    end else begin
      if (issue) pc <= pc_next(pc);
      s1_v  <= issue;
      s1_pc <= pc;
      s2_v  <= s1_v;
      s2_pc <= s1_pc;
    end
  end

  assign push_entry = '{pc: s2_pc, instr: imem_data};
  assign push       = s2_v && !redirect_valid;
  assign pop        = if_valid && if_ready;

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head),
    .count     (buf_count)
  );

  assign imem_addr = rst ? RESET_PC : pc;
  assign if_valid  = !rst && (buf_count != '0);
  assign if_pc     = if_valid ? head.pc    : '0;
  assign if_instr  = if_valid ? head.instr : '0;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - randomized and directed bench for ifu_fetch against a queue-level fetch model
module tb_ifu_fetch;

  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  ifu_fetch #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Instruction memory: data for an address returns two cycles later.
  logic [31:0] a1 = '0;
  logic [31:0] a2 = '0;
  always @(posedge clk) begin
    a1 <= imem_addr;
    a2 <= a1;
  end
  assign imem_data = mem_f(a2);

  typedef struct {
    logic [31:0] pc;
    int          c;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc = RPC;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] alog[$];
  logic        vlog[$];
  logic [31:0] dq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    alog.delete();
    vlog.delete();
    dq.delete();
  endtask

  // One clock cycle: drive inputs, compare against the model mid-cycle, then advance the model.
  task automatic cycle(input logic r, input logic rv, input logic [31:0] rp, input logic rd);
    logic        exp_v;
    logic        iss;
    rst = r;
    redirect_valid = rv;
    redirect_pc = rp;
    if_ready = rd;
    @(negedge clk);
    exp_v = !r && (q.size() > 0) && (q[0].c <= cyc - 3);
    iss   = !r && !rv && (q.size() < DEPTH);
    chk("imem_addr", imem_addr, r ? RPC : m_pc);
    chk("if_valid", {31'b0, if_valid}, {31'b0, exp_v});
    if (exp_v && if_valid) begin
      chk("if_pc", if_pc, q[0].pc);
      chk("if_instr", if_instr, mem_f(q[0].pc));
    end
    if (r) begin
      chk("rst_if_pc", if_pc, 32'h0);
      chk("rst_if_instr", if_instr, 32'h0);
    end
    alog.push_back(imem_addr);
    vlog.push_back(if_valid);
    if (if_valid && if_ready) dq.push_back(if_pc);
    @(posedge clk);
    if (r) begin
      q.delete();
      m_pc = RPC;
    end else if (rv) begin
      q.delete();
      m_pc = {rp[31:2], 2'b00};
    end else begin
      if (exp_v && rd) void'(q.pop_front());
      if (iss) begin
        q.push_back('{pc: m_pc, c: cyc});
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
    #1;
  endtask

  function automatic int count_below(input logic [31:0] lim);
    int n = 0;
    foreach (dq[i]) if (dq[i] < lim) n++;
    return n;
  endfunction

  initial begin
    #1;
    // Reset, then free-running fetch
    repeat (2) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    chk("reset_addr", alog[1], 32'h0);
    chk("reset_valid", {31'b0, vlog[1]}, 32'h0);
    clear_logs();
    repeat (8) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("addr0", alog[0], 32'h0);
    chk("addr1", alog[1], 32'h4);
    chk("addr2", alog[2], 32'h8);
    chk("valid_c2", {31'b0, vlog[2]}, 32'h0);
    chk("valid_c3", {31'b0, vlog[3]}, 32'h1);
    chk("dlv0", dq[0], 32'h0);
    chk("dlv1", dq[1], 32'h4);
    chk("dlv2", dq[2], 32'h8);
    chk("dlv_count", dq.size(), 32'd5);

    // Backpressure
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    clear_logs();
    repeat (10) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    chk("bp_addr_hold4", alog[4], 32'h10);
    chk("bp_addr_hold9", alog[9], 32'h10);
    chk("bp_valid", {31'b0, vlog[9]}, 32'h1);
    repeat (8) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("bp_dlv0", dq[0], 32'h0);
    chk("bp_dlv1", dq[1], 32'h4);
    chk("bp_dlv2", dq[2], 32'h8);
    chk("bp_dlv3", dq[3], 32'hC);
    chk("bp_dlv4", dq[4], 32'h10);

    // Redirect with two buffered and two in flight
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    clear_logs();
    repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 32'h100, 1'b0);
    clear_logs();
    repeat (8) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rd_dlv0", dq[0], 32'h100);
    chk("rd_dlv1", dq[1], 32'h104);
    chk("rd_stale", count_below(32'h100), 32'd0);

    // Unaligned redirect coinciding with a pop
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (5) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    clear_logs();
    cycle(1'b0, 1'b1, 32'h103, 1'b1);
    chk("rd_pop_valid", {31'b0, vlog[0]}, 32'h1);
    clear_logs();
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rd_empty", {31'b0, vlog[0]}, 32'h0);
    chk("rd_align_addr", alog[0], 32'h100);
    repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rd_align_dlv", dq[0], 32'h100);

    // Address wrap
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    clear_logs();
    repeat (8) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("wrap0", dq[0], 32'hFFFF_FFFC);
    chk("wrap1", dq[1], 32'h0);

    // One-cycle reset mid-stream
    cycle(1'b0, 1'b1, 32'h200, 1'b1);
    repeat (10) cycle(1'b0, 1'b0, 32'h0, 1'($urandom_range(0, 1)));
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    clear_logs();
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("mrst_valid", {31'b0, vlog[0]}, 32'h0);
    chk("mrst_addr", alog[0], RPC);
    repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("mrst_dlv0", dq[0], RPC);
    chk("mrst_stale", dq.size() - count_below(32'h200), 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 99) == 0),
            1'($urandom_range(0, 99) < 3),
            $urandom(),
            1'($urandom_range(0, 99) < 70));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
